bg_mem_ctrl: RTL and testbench
==============================

# bg_mem_ctrl

Controller that owns both ports of the background frame memory: 720×720 4-bit palette indices, one sync write port, one sync read port with 1-cycle read latency, read-old-data on same-address collision. It sits between the memory and three clients:
- the VGA pixel fetch, which has a fixed-latency, never-stalled read;
- game-logic readback (collision lookups) with a valid/ready handshake;
- a level loader write stream, plus an internal fill engine that clears the frame to one colour.

It also applies a per-frame horizontal scroll with wrap-around to display fetches.

## Interface
Parameters:
- WIDTH, 720, pixels per row
- HEIGHT, 720, rows
- ADDR_W, 19, memory address width
- DATA_W, 4, palette index width

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at vsync; latches scroll_x
- scroll_x  in  10  horizontal scroll offset
- disp_req  in  1  display fetch request
- disp_x  in  10  display fetch column
- disp_y  in  10  display fetch row
- disp_valid  out  1  disp_data valid
- disp_data  out  DATA_W  fetched pixel
- rd_valid  in  1  readback request
- rd_ready  out  1  readback accepted this cycle
- rd_addr  in  ADDR_W  readback linear address (unscrolled)
- rd_data_valid  out  1  rd_data valid
- rd_data  out  DATA_W  readback result
- wr_valid  in  1  loader write request
- wr_ready  out  1  loader write accepted this cycle
- wr_addr  in  ADDR_W  loader write address
- wr_data  in  DATA_W  loader write data
- fill_start  in  1  start a full-frame fill
- fill_color  in  DATA_W  fill value; latched at start
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after the last fill write
- mem_we  out  1  memory write enable
- mem_write_address  out  ADDR_W  memory write address
- mem_data_In  out  DATA_W  memory write data
- mem_read_address  out  ADDR_W  memory read address
- mem_data_Out  in  DATA_W  memory read data

## Operation
Read port:
- Display has absolute priority.
- rd_ready = ~disp_req (combinational).
- A readback is accepted when rd_valid && rd_ready.
- An owner bit travels with each read down a 2-stage pipeline and steers the result to disp_valid or rd_data_valid.
- disp_data and rd_data are both driven from mem_data_Out. Each is meaningful only while its valid is high.

Display scroll:
- scroll_lat is loaded from scroll_x on frame_start. A scroll_x ≥ WIDTH loads 0.
- xs = disp_x + scroll_lat. If xs ≥ WIDTH, then xs = xs − WIDTH.
- Address = disp_y·WIDTH + xs, computed at 19 bits with no truncation.
- Coordinates out of range (disp_x ≥ WIDTH or disp_y ≥ HEIGHT) still fetch, but the address is forced to 0.

Write port FSM, states IDLE and FILL:
- IDLE:
  - wr_ready = 1.
  - A write is accepted when wr_valid && wr_ready; it is registered onto mem_we / mem_write_address / mem_data_In for one cycle.
  - fill_start moves to FILL, latches fill_color and clears fill_addr to 0.
  - If fill_start and wr_valid occur in the same cycle, fill wins and the write is not accepted.
- FILL:
  - wr_ready = 0 and fill_busy = 1.
  - One write per cycle of fill_color at fill_addr; fill_addr increments.
  - After writing address WIDTH·HEIGHT−1: return to IDLE and pulse fill_done in the following cycle.
  - fill_start is ignored while in FILL.
- Reset_n low mid-fill aborts it: state returns to IDLE, no fill_done pulse, and memory contents are left partially filled.

Reset values:
- All registered outputs and pipeline valids are 0; scroll_lat = 0; state = IDLE.
- mem_we = 0 and both memory addresses = 0.
- After reset: wr_ready = 1, rd_ready follows disp_req, fill_busy = 0, fill_done = 0.

## Timing
- Display latency is exactly 2 cycles:
  - disp_req in cycle t registers mem_read_address at the end of t.
  - The memory registers data at the end of t+1.
  - disp_valid = 1 in cycle t+2.
- Back-to-back disp_req every cycle gives one result every cycle.
- Readback latency is 2 cycles from acceptance. The requester holds rd_valid and rd_addr until rd_ready is high.
- Loader write: accepted in cycle t, appears on mem_we in cycle t+1.
- A fill takes exactly WIDTH·HEIGHT = 518400 write cycles:
  - fill_busy rises the cycle after fill_start and falls after the last write;
  - fill_done is high in the cycle after fill_busy falls.
- A read and a write to the same address in the same cycle returns the old data. No bypass is performed.
- A frame_start arriving mid-frame changes the scroll from the next fetch onward.

## Structure
- Package bg_mem_pkg holds:
  - WIDTH, HEIGHT, ADDR_W, DATA_W constants;
  - the write FSM state enum (IDLE, FILL);
  - the read owner enum (OWN_DISP, OWN_RD).
- One sub-module, bg_addr_gen: registered scroll/wrap and y·WIDTH+x address computation, 1-cycle latency.
- The read arbiter and write FSM live in the top module.

## Test plan
- Reset, then fill_start with fill_color = 4'hA, reading stimulus idle:
  - fill_busy is high for exactly 518400 cycles and fill_done pulses once;
  - display reads of (0,0) and (719,719) then return 4'hA.
- scroll_x = 5 latched, disp_req at (717,3) → mem_read_address = 3·720 + 2 = 2162; disp_valid 2 cycles later.
- disp_req held every cycle with rd_valid = 1:
  - rd_ready stays 0;
  - when disp_req drops for one cycle, exactly one readback is accepted and rd_data_valid pulses 2 cycles later.
- Loader write to addr 100 with data 4'h3, then readback of addr 100:
  - mem_we = 1 one cycle after acceptance;
  - readback returns 4'h3.
- fill_start in the same cycle as wr_valid → wr_ready = 0 and the write is held until the fill completes.
- Reset_n asserted at fill cycle 1000 → fill_busy = 0 immediately, no fill_done, wr_ready = 1 after release.

Source files
------------

// File: rtl/bg_mem_pkg.sv
// Shared constants and state/owner encodings for the background frame memory controller.
package bg_mem_pkg;
  localparam int unsigned WIDTH  = 720;
  localparam int unsigned HEIGHT = 720;
  localparam int unsigned ADDR_W = 19;
  localparam int unsigned DATA_W = 4;

  typedef enum logic { IDLE, FILL } wr_state_e;
  typedef enum logic { OWN_DISP, OWN_RD } rd_owner_e;
endpackage

// File: rtl/bg_addr_gen.sv
// Registered read-address generator: scrolled/wrapped display address or a pass-through readback address.
module bg_addr_gen
  import bg_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = bg_mem_pkg::WIDTH,
  parameter int unsigned HEIGHT = bg_mem_pkg::HEIGHT,
  parameter int unsigned ADDR_W = bg_mem_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              frame_start_i,
  input  logic [9:0]        scroll_x_i,
  input  logic              disp_req_i,
  input  logic [9:0]        disp_x_i,
  input  logic [9:0]        disp_y_i,
  input  logic              alt_load_i,
  input  logic [ADDR_W-1:0] alt_addr_i,
  output logic [ADDR_W-1:0] addr_o
);
  logic [9:0]        scroll_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       xs_sum;
  logic [ADDR_W-1:0] xs;
  logic [ADDR_W-1:0] disp_addr;

  // scroll_q < WIDTH is guaranteed at load, so one conditional subtract wraps.
  always_comb begin
    xs_sum = {1'b0, disp_x_i} + {1'b0, scroll_q};
    xs     = ADDR_W'(xs_sum);
    if (xs_sum >= 11'(WIDTH)) xs = ADDR_W'(xs_sum - 11'(WIDTH));
    disp_addr = ADDR_W'(disp_y_i) * ADDR_W'(WIDTH) + xs;
    if (disp_x_i >= 10'(WIDTH) || disp_y_i >= 10'(HEIGHT)) disp_addr = '0;

    addr_d = addr_q;
    if (disp_req_i)      addr_d = disp_addr;
    else if (alt_load_i) addr_d = alt_addr_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scroll_q <= '0;
      addr_q   <= '0;
    end else begin
      if (frame_start_i) scroll_q <= (scroll_x_i >= 10'(WIDTH)) ? '0 : scroll_x_i;
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
endmodule

// File: rtl/bg_mem_ctrl.sv
// Background frame memory controller: display/readback read arbitration, loader writes and full-frame fill.
module bg_mem_ctrl
  import bg_mem_pkg::*;
#(
  parameter int unsigned WIDTH  = bg_mem_pkg::WIDTH,
  parameter int unsigned HEIGHT = bg_mem_pkg::HEIGHT,
  parameter int unsigned ADDR_W = bg_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = bg_mem_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        scroll_x,
  input  logic              disp_req,
  input  logic [9:0]        disp_x,
  input  logic [9:0]        disp_y,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_data_In,
  output logic [ADDR_W-1:0] mem_read_address,
  input  logic [DATA_W-1:0] mem_data_Out
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  logic      rd_acc;
  logic      s1_vld_q, s2_vld_q;
  rd_owner_e s1_own_q, s2_own_q;

  assign rd_ready = ~disp_req;
  assign rd_acc   = rd_valid & rd_ready;

  bg_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .frame_start_i(frame_start),
    .scroll_x_i   (scroll_x),
    .disp_req_i   (disp_req),
    .disp_x_i     (disp_x),
    .disp_y_i     (disp_y),
    .alt_load_i   (rd_acc),
    .alt_addr_i   (rd_addr),
    .addr_o       (mem_read_address)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld_q <= 1'b0;
      s1_own_q <= OWN_DISP;
      s2_vld_q <= 1'b0;
      s2_own_q <= OWN_DISP;
    end else begin
      s1_vld_q <= disp_req | rd_acc;
      s1_own_q <= disp_req ? OWN_DISP : OWN_RD;
      s2_vld_q <= s1_vld_q;
      s2_own_q <= s1_own_q;
    end
  end

  assign disp_valid    = s2_vld_q && (s2_own_q == OWN_DISP);
  assign rd_data_valid = s2_vld_q && (s2_own_q == OWN_RD);
  assign disp_data     = mem_data_Out;
  assign rd_data       = mem_data_Out;

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0] fill_color_q, fill_color_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              done_q;

  always_comb begin
    state_d      = state_q;
    fill_addr_d  = fill_addr_q;
    fill_color_d = fill_color_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    last_d       = 1'b0;
    wr_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ready = ~fill_start;
        if (fill_start) begin
          state_d      = FILL;
          fill_addr_d  = '0;
          fill_color_d = fill_color;
        end else if (wr_valid) begin
          we_d    = 1'b1;
          waddr_d = wr_addr;
          wdata_d = wr_data;
        end
      end
      FILL: begin
        we_d        = 1'b1;
        waddr_d     = fill_addr_q;
        wdata_d     = fill_color_q;
        fill_addr_d = fill_addr_q + 1'b1;
        if (fill_addr_q == LAST_ADDR) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // fill_done trails the last write on mem_we by one cycle, hence the two-stage delay.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      fill_addr_q  <= '0;
      fill_color_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_addr_q  <= fill_addr_d;
      fill_color_q <= fill_color_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
      done_q       <= last_q;
    end
  end

  assign fill_busy         = (state_q == FILL);
  assign fill_done         = done_q;
  assign mem_we            = we_q;
  assign mem_write_address = waddr_q;
  assign mem_data_In       = wdata_q;
endmodule

// File: tb/tb_bg_mem_ctrl.sv
// Directed bench for bg_mem_ctrl on a reduced 40x30 frame with a behavioural read-old-data memory.
module tb_bg_mem_ctrl;
  localparam int unsigned W  = 40;
  localparam int unsigned H  = 30;
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = 19;
  localparam int unsigned DW = 4;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [9:0]    scroll_x = '0;
  logic          disp_req = 1'b0;
  logic [9:0]    disp_x = '0;
  logic [9:0]    disp_y = '0;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          rd_valid = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          fill_start = 1'b0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy;
  logic          fill_done;
  logic          mem_we;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_data_In;
  logic [AW-1:0] mem_read_address;
  logic [DW-1:0] mem_data_Out = '0;

  int n_checks = 0;
  int n_errors = 0;

  bg_mem_ctrl #(
    .WIDTH (W),
    .HEIGHT(H),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .frame_start      (frame_start),
    .scroll_x         (scroll_x),
    .disp_req         (disp_req),
    .disp_x           (disp_x),
    .disp_y           (disp_y),
    .disp_valid       (disp_valid),
    .disp_data        (disp_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_addr          (rd_addr),
    .rd_data_valid    (rd_data_valid),
    .rd_data          (rd_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .fill_start       (fill_start),
    .fill_color       (fill_color),
    .fill_busy        (fill_busy),
    .fill_done        (fill_done),
    .mem_we           (mem_we),
    .mem_write_address(mem_write_address),
    .mem_data_In      (mem_data_In),
    .mem_read_address (mem_read_address),
    .mem_data_Out     (mem_data_Out)
  );

  always #5 Clk = ~Clk;

  // Frame memory: synchronous write, synchronous read returning pre-write data.
  logic [DW-1:0] mem [N];
  always @(posedge Clk) begin
    if (mem_we && mem_write_address < AW'(N)) mem[mem_write_address] <= mem_data_In;
    mem_data_Out <= (mem_read_address < AW'(N)) ? mem[mem_read_address] : '0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic disp_read(input string tag, input int x, input int y, input int exp_addr,
                           input int exp_data);
    disp_req = 1'b1;
    disp_x   = 10'(x);
    disp_y   = 10'(y);
    tick();
    disp_req = 1'b0;
    chk({tag, "_addr"}, 32'(mem_read_address), 32'(exp_addr));
    chk({tag, "_v1"}, 32'(disp_valid), 32'd0);
    tick();
    chk({tag, "_v2"}, 32'(disp_valid), 32'd1);
    chk({tag, "_data"}, 32'(disp_data), 32'(exp_data));
  endtask

  task automatic set_scroll(input int s);
    scroll_x    = 10'(s);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int cnt;

    #2;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_write_address), 32'd0);
    chk("rst_raddr", 32'(mem_read_address), 32'd0);
    chk("rst_busy", 32'(fill_busy), 32'd0);
    chk("rst_done", 32'(fill_done), 32'd0);
    chk("rst_dvalid", 32'(disp_valid), 32'd0);
    chk("rst_rvalid", 32'(rd_data_valid), 32'd0);
    chk("rst_wready", 32'(wr_ready), 32'd1);
    chk("rst_rready", 32'(rd_ready), 32'd1);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    // Full fill with 0xA
    fill_color = 4'hA;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    cnt = 0;
    while (fill_busy && cnt < 5000) begin
      if (fill_done) chk("fill_done_early", 32'(fill_done), 32'd0);
      cnt++;
      tick();
    end
    chk("fill_busy_len", 32'(cnt), 32'(N));
    chk("fill_last_we", 32'(mem_we), 32'd1);
    chk("fill_last_addr", 32'(mem_write_address), 32'(N - 1));
    chk("fill_last_data", 32'(mem_data_In), 32'hA);
    chk("fill_done_pre", 32'(fill_done), 32'd0);
    tick();
    chk("fill_done_pulse", 32'(fill_done), 32'd1);
    chk("fill_we_off", 32'(mem_we), 32'd0);
    tick();
    chk("fill_done_off", 32'(fill_done), 32'd0);

    disp_read("rd00", 0, 0, 0, 'hA);
    disp_read("rd_last", W - 1, H - 1, N - 1, 'hA);

    // Scroll and wrap
    set_scroll(5);
    disp_read("scr_wrap", 37, 3, 3 * W + 2, 'hA);
    disp_read("scr_nowrap", 10, 2, 2 * W + 15, 'hA);
    disp_read("oob_x", W, 0, 0, 'hA);
    disp_read("oob_y", 3, H, 0, 'hA);
    set_scroll(50);
    disp_read("scr_big", 37, 3, 3 * W + 37, 'hA);
    set_scroll(0);

    // Display priority over readback
    disp_req = 1'b1;
    disp_x   = '0;
    disp_y   = '0;
    rd_valid = 1'b1;
    rd_addr  = AW'(100);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("arb_rready0", 32'(rd_ready), 32'd0);
      tick();
    end
    disp_req = 1'b0;
    #1;
    chk("arb_rready1", 32'(rd_ready), 32'd1);
    tick();
    disp_req = 1'b1;
    rd_valid = 1'b0;
    chk("arb_rv_t1", 32'(rd_data_valid), 32'd0);
    chk("arb_dv_t1", 32'(disp_valid), 32'd1);
    tick();
    disp_req = 1'b0;
    chk("arb_rv_t2", 32'(rd_data_valid), 32'd1);
    chk("arb_rdata", 32'(rd_data), 32'hA);
    chk("arb_dv_t2", 32'(disp_valid), 32'd0);
    tick();
    chk("arb_rv_t3", 32'(rd_data_valid), 32'd0);
    chk("arb_dv_t3", 32'(disp_valid), 32'd1);
    tick();

    // Loader write then readback
    wr_valid = 1'b1;
    wr_addr  = AW'(100);
    wr_data  = 4'h3;
    #1;
    chk("ld_wready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("ld_we", 32'(mem_we), 32'd1);
    chk("ld_waddr", 32'(mem_write_address), 32'd100);
    chk("ld_wdata", 32'(mem_data_In), 32'h3);
    tick();
    chk("ld_we_off", 32'(mem_we), 32'd0);
    rd_valid = 1'b1;
    rd_addr  = AW'(100);
    #1;
    chk("rb_rready", 32'(rd_ready), 32'd1);
    tick();
    rd_valid = 1'b0;
    tick();
    chk("rb_valid", 32'(rd_data_valid), 32'd1);
    chk("rb_data", 32'(rd_data), 32'h3);

    // Fill beats a simultaneous loader write; write waits for the fill
    fill_color = 4'h5;
    fill_start = 1'b1;
    wr_valid   = 1'b1;
    wr_addr    = AW'(200);
    wr_data    = 4'h7;
    #1;
    chk("col_wready0", 32'(wr_ready), 32'd0);
    tick();
    fill_start = 1'b0;
    cnt = 0;
    while (!wr_ready && cnt < 5000) begin
      cnt++;
      tick();
    end
    chk("col_hold_len", 32'(cnt), 32'(N));
    chk("col_last_fill", 32'(mem_write_address), 32'(N - 1));
    tick();
    wr_valid = 1'b0;
    chk("col_we", 32'(mem_we), 32'd1);
    chk("col_waddr", 32'(mem_write_address), 32'd200);
    chk("col_wdata", 32'(mem_data_In), 32'h7);
    chk("col_done", 32'(fill_done), 32'd1);
    tick();
    disp_read("col_rd200", 0, 5, 200, 'h7);
    disp_read("col_rd199", 39, 4, 199, 'h5);

    // Reset at fill cycle 1000
    fill_color = 4'h9;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    repeat (999) tick();
    chk("abort_busy_pre", 32'(fill_busy), 32'd1);
    Reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(fill_busy), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_wready", 32'(wr_ready), 32'd1);
    tick();
    tick();
    Reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (fill_done) cnt++;
      tick();
    end
    chk("abort_no_done", 32'(cnt), 32'd0);
    chk("abort_wready_rel", 32'(wr_ready), 32'd1);
    chk("abort_busy_rel", 32'(fill_busy), 32'd0);
    disp_read("abort_rd5", 5, 0, 5, 'h9);
    disp_read("abort_rd1190", 30, 29, 1190, 'h5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
